// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM controller engines and the command
// arbiter. Commands are encoded as {cs_n, ras_n, cas_n, we_n}.
// Self-refresh entry uses the auto-refresh encoding with CKE driven low.
// ---------------------------------------------------------------------------
package sdram_pkg;

    localparam logic [3:0] CMD_NOP        = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;
    localparam logic [3:0] CMD_AREF       = 4'b0001;
    localparam logic [3:0] CMD_SREF_ENTRY = CMD_AREF;
    localparam logic [3:0] CMD_MRS        = 4'b0000;
    localparam logic [3:0] CMD_ACT        = 4'b0011;
    localparam logic [3:0] CMD_WRITE      = 4'b0100;
    localparam logic [3:0] CMD_READ       = 4'b0101;

    // Arbiter ownership states: which engine currently owns the command bus.
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_AREF  = 3'd2,
        ST_SREF  = 3'd3,
        ST_WRITE = 3'd4,
        ST_READ  = 3'd5
    } arb_state_t;

endpackage

// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
// Owns the physical SDRAM command bus and grants it to one engine at a time
// (init, auto-refresh, self-refresh, write, read). The granted engine's
// CKE/command/bank/address are muxed combinationally onto the pins; the bus
// returns to NOP when the engine signals completion.
//
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   init_*                      init engine bus, init_end level done flag
//   aref_*                      auto-refresh request, bus, done pulse
//   sref_*                      self-refresh request, bus (incl. CKE), done
//   wr_*                        write request, bus, done, DQ enable and data
//   rd_*                        read request, bus, done pulse
//   aref_en/sref_en/wr_en/rd_en level grants back to the engines
//   sdram_*                     device pins; sdram_dq is bidirectional
//   rd_data                     continuous copy of sdram_dq for the reader
// ---------------------------------------------------------------------------
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int BA_W   = 2,
    parameter int DQ_W   = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,

    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_end,

    input  logic              aref_req,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              aref_end,

    input  logic              sref_req,
    input  logic              sref_cke,
    input  logic [3:0]        sref_cmd,
    input  logic [BA_W-1:0]   sref_ba,
    input  logic [ADDR_W-1:0] sref_addr,
    input  logic              sref_done,

    input  logic              wr_req,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_end,
    input  logic              wr_sdram_en,
    input  logic [DQ_W-1:0]   wr_data,

    input  logic              rd_req,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_end,

    output logic              aref_en,
    output logic              sref_en,
    output logic              wr_en,
    output logic              rd_en,

    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DQ_W-1:0]   sdram_dq,
    output logic [DQ_W-1:0]   rd_data
);

    arb_state_t        state;
    arb_state_t        next_state;
    logic [3:0]        cmd_mux;

    // State register is the only storage; reset forces the init engine
    // back onto the bus immediately.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    // Fixed-priority grant from IDLE; only the owner's done pulse releases
    // the bus, so every hand-over passes through one IDLE (NOP) cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:  if (init_end)  next_state = ST_IDLE;
            ST_IDLE: begin
                if (aref_req)        next_state = ST_AREF;
                else if (sref_req)   next_state = ST_SREF;
                else if (wr_req)     next_state = ST_WRITE;
                else if (rd_req)     next_state = ST_READ;
            end
            ST_AREF:  if (aref_end)  next_state = ST_IDLE;
            ST_SREF:  if (sref_done) next_state = ST_IDLE;
            ST_WRITE: if (wr_end)    next_state = ST_IDLE;
            ST_READ:  if (rd_end)    next_state = ST_IDLE;
            default:                 next_state = ST_INIT;
        endcase
    end

    // Pin mux straight from the registered state: no added latency between
    // an engine's command and the device pins.
    always_comb begin
        cmd_mux    = CMD_NOP;
        sdram_ba   = '0;
        sdram_addr = '0;
        sdram_cke  = 1'b1;
        case (state)
            ST_INIT: begin
                cmd_mux    = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                cmd_mux    = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            ST_SREF: begin
                cmd_mux    = sref_cmd;
                sdram_ba   = sref_ba;
                sdram_addr = sref_addr;
                sdram_cke  = sref_cke;
            end
            ST_WRITE: begin
                cmd_mux    = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                cmd_mux    = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: begin
                cmd_mux    = CMD_NOP;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;

    assign aref_en = (state == ST_AREF);
    assign sref_en = (state == ST_SREF);
    assign wr_en   = (state == ST_WRITE);
    assign rd_en   = (state == ST_READ);

    // DQ is only driven while the write engine owns the bus and asks for it.
    assign sdram_dq = (state == ST_WRITE && wr_sdram_en) ? wr_data : {DQ_W{1'bz}};
    assign rd_data  = sdram_dq;

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Command arbiter that sits directly downstream of the SDRAM initialisation, auto-refresh, self-refresh, write and read engines and owns the physical SDRAM command bus. It grants exactly one engine at a time, muxes that engine's CKE/command/bank/address (and write data) onto the device pins, and returns the bus to idle when the engine signals completion. The self-refresh engine's `self_ref_en` is driven from this block's `sref_en` grant, and its `sdram_cke/cmd/ba/addr/self_ref_done` are consumed here.

## Interface
- `ADDR_W`, default 12: SDRAM address width.
- `BA_W`, default 2: bank address width.
- `DQ_W`, default 16: data bus width.
- `sys_clk` input 1: system clock, all logic on rising edge.
- `sys_rst_n` input 1: asynchronous active-low reset.
- `init_cmd` input 4, `init_ba` input BA_W, `init_addr` input ADDR_W, `init_end` input 1: init engine bus and level done flag.
- `aref_req` input 1, `aref_cmd` input 4, `aref_ba` input BA_W, `aref_addr` input ADDR_W, `aref_end` input 1: auto-refresh request, bus, 1-cycle done pulse.
- `sref_req` input 1, `sref_cke` input 1, `sref_cmd` input 4, `sref_ba` input BA_W, `sref_addr` input ADDR_W, `sref_done` input 1: self-refresh request, bus, 1-cycle done pulse.
- `wr_req` input 1, `wr_cmd` input 4, `wr_ba` input BA_W, `wr_addr` input ADDR_W, `wr_end` input 1, `wr_sdram_en` input 1, `wr_data` input DQ_W: write engine bus, done pulse, DQ drive enable and data.
- `rd_req` input 1, `rd_cmd` input 4, `rd_ba` input BA_W, `rd_addr` input ADDR_W, `rd_end` input 1: read engine bus and done pulse.
- `aref_en`, `sref_en`, `wr_en`, `rd_en` output 1 each: level grants.
- `sdram_cke` output 1; `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n` output 1 each (cmd bits 3..0); `sdram_ba` output BA_W; `sdram_addr` output ADDR_W.
- `sdram_dq` inout DQ_W: device data bus.
- `rd_data` output DQ_W: continuous copy of `sdram_dq` for the read engine.

## Operation
- States: INIT, IDLE, AREF, SREF, WRITE, READ; state register is the only storage.
- INIT: bus = init bus; `init_end`=1 -> IDLE. INIT is never re-entered except by reset.
- IDLE: bus = NOP (4'b0111), ba=0, addr=0. Fixed priority on requests sampled this cycle: `aref_req` > `sref_req` > `wr_req` > `rd_req` -> AREF/SREF/WRITE/READ. No request -> stay.
- AREF/SREF/WRITE/READ: bus = granted engine's bus; its end pulse (`aref_end`/`sref_done`/`wr_end`/`rd_end`) -> IDLE. End pulses from non-granted engines are ignored.
- Grant `x_en` = (state == X); no other output asserts it.
- `sdram_cke` = `sref_cke` in SREF, else 1.
- `sdram_dq` driven with `wr_data` only when state == WRITE and `wr_sdram_en`=1; otherwise high-Z.
- Requests arriving while busy are not latched; requesters hold `req` until granted.

## Timing
- Reset (async assert): state=INIT; outputs follow init bus; all grants 0; `sdram_cke`=1; `sdram_dq` high-Z. Release is synchronised by the state register only.
- Bus muxing is combinational from registered state: zero added latency from an engine's cmd input to the pins.
- Request sampled at edge N in IDLE -> grant high and bus switched from edge N+1.
- End pulse at edge N -> state IDLE, grant low, bus NOP from edge N+1; next grant earliest N+2 (one guaranteed NOP cycle between owners).
- Simultaneous end and new request in same cycle: end processed, request waits for IDLE.
- Reset mid-operation (any state): immediate return to INIT, grants drop asynchronously.

## Structure
- Shared package `sdram_pkg`: command constants (NOP 4'b0111, PRECHARGE 4'b0010, AREF 4'b0001, SREF_ENTRY as AREF with CKE low, MRS 4'b0000, ACT 4'b0011, WRITE 4'b0100, READ 4'b0101) and the arbiter state enum.
- No sub-module; single flat module.

## Test plan
- Reset then `init_end`=1 at cycle 5 -> pins follow `init_cmd` until cycle 5, NOP with ba=0/addr=0 from cycle 6, all grants 0.
- IDLE, `aref_req`,`sref_req`,`wr_req`,`rd_req` all 1 -> `aref_en`=1 next cycle; after `aref_end` pulse one NOP cycle, then `sref_en`=1.
- SREF grant, self-refresh engine drives `sref_cke`=0 for 15 cycles then `sref_done` -> `sdram_cke` tracks 0, returns to 1 and `sref_en`=0 the cycle after `sref_done`.
- WRITE grant with `wr_sdram_en`=1, `wr_data`=16'hA5A5 -> `sdram_dq`=16'hA5A5; `wr_sdram_en`=0 or READ state -> `sdram_dq` high-Z, `rd_data` equals externally driven 16'h1234.
- In READ, pulse `aref_end` and `wr_end` -> ignored, `rd_en` stays 1 until `rd_end`.
- Assert `sys_rst_n`=0 mid-WRITE -> `wr_en`=0 and pins show init bus without waiting for a clock edge.
